// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, register index, branch encoding and the
// EX/MEM pipeline register bundle, plus small helpers used by the EX/MEM latch.
package cpu_types_pkg;

   localparam int WORD_W = 32;
   localparam int REG_W  = 5;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [REG_W-1:0]  regbits_t;

   // Branch kind decoded in ID and resolved at the EX/MEM boundary.
   typedef enum logic [1:0] {
      BR_NONE = 2'd0,
      BR_EQ   = 2'd1,
      BR_NE   = 2'd2,
      BR_JMP  = 2'd3
   } branch_t;

   // Sticky halt tracking for the EX/MEM boundary.
   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } halt_state_t;

   // Everything held in the EX/MEM pipeline register.
   typedef struct packed {
      logic     valid;
      word_t    alu_out;
      word_t    store_data;
      word_t    pc_plus4;
      regbits_t rd;
      logic     regwen;
      logic     memren;
      logic     memwen;
      logic     br_taken;
      word_t    br_target;
      logic     ovf_exc;
      logic     negative;   // kept for future sign-based branches
   } ex_mem_t;

   // A trapping signed op that overflowed becomes an exception.
   function automatic logic overflow_trap(input logic ovf_chk,
                                          input logic overflow_flag);
      return ovf_chk & overflow_flag;
   endfunction

   // Register contents after reset: all clear, redirect points at the boot PC.
   function automatic ex_mem_t ex_mem_reset(input word_t reset_pc);
      ex_mem_t r;
      r           = '0;
      r.br_target = reset_pc;
      return r;
   endfunction

endpackage : cpu_types_pkg

// File: rtl/branch_resolve.sv
// Combinational branch condition evaluation from ALU flags. Shared with any
// later early-branch logic, so it carries no pipeline state of its own.
module branch_resolve
   import cpu_types_pkg::*;
(
   input  branch_t br_type,
   input  logic    zero_flag,
   input  logic    negative_flag,
   output logic    taken
);

   // The negative flag is wired in now so BLTZ/BGEZ can be added here later.
   logic unused_negative;
   assign unused_negative = negative_flag;

   // Decide whether the branch redirects fetch.
   // NOTE: every output of an always_comb gets a default first so no path
   // through the block leaves it unassigned, which would infer a latch.
   always_comb begin
      taken = 1'b0;
      unique case (br_type)
         BR_NONE: taken = 1'b0;
         BR_EQ:   taken = zero_flag;
         BR_NE:   taken = ~zero_flag;
         BR_JMP:  taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

endmodule : branch_resolve

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline boundary. Registers the ALU result with its control bits,
// resolves conditional branches, squashes side effects of overflowing signed
// ops, and keeps a sticky halt plus a retired-instruction counter.
module ex_mem_latch
   import cpu_types_pkg::*;
#(
   parameter int    CNT_W    = 32,
   parameter word_t RESET_PC = 32'h0000_0000
)(
   input  logic             CLK,
   input  logic             RST,
   input  logic             enable,
   input  logic             flush,
   input  logic             ex_valid,
   input  word_t            alu_out,
   input  logic             zero_flag,
   input  logic             negative_flag,
   input  logic             overflow_flag,
   input  logic             ovf_chk,
   input  branch_t          br_type,
   input  word_t            br_target,
   input  word_t            pc_plus4,
   input  regbits_t         rd,
   input  logic             regwen,
   input  logic             memren,
   input  logic             memwen,
   input  word_t            store_data,
   input  logic             halt,
   output logic             mem_valid,
   output word_t            mem_alu_out,
   output word_t            mem_store_data,
   output word_t            mem_pc_plus4,
   output regbits_t         mem_rd,
   output logic             mem_regwen,
   output logic             mem_memren,
   output logic             mem_memwen,
   output logic             mem_br_taken,
   output word_t            mem_br_target,
   output logic             mem_ovf_exc,
   output logic             mem_halt,
   output logic [CNT_W-1:0] retired_cnt
);

   ex_mem_t          ex_mem_q, ex_mem_d;
   halt_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic exc;
   logic cond_taken;

   assign exc = overflow_trap(ovf_chk, overflow_flag);

   branch_resolve u_branch_resolve (
      .br_type       (br_type),
      .zero_flag     (zero_flag),
      .negative_flag (negative_flag),
      .taken         (cond_taken)
   );

   // Next pipeline contents, counter and halt state; priority is
   // halted > flush > stall > capture.
   always_comb begin
      ex_mem_d = ex_mem_q;
      cnt_d    = cnt_q;
      state_d  = state_q;

      if (state_q == ST_HALTED || flush) begin
         ex_mem_d = '0;
      end else if (enable) begin
         if (ex_valid) begin
            ex_mem_d.valid      = 1'b1;
            ex_mem_d.alu_out    = alu_out;
            ex_mem_d.store_data = store_data;
            ex_mem_d.pc_plus4   = pc_plus4;
            ex_mem_d.rd         = rd;
            ex_mem_d.regwen     = regwen & ~exc;
            ex_mem_d.memren     = memren & ~exc;
            ex_mem_d.memwen     = memwen & ~exc;
            ex_mem_d.br_taken   = cond_taken & ~exc;
            ex_mem_d.br_target  = br_target;
            ex_mem_d.ovf_exc    = exc;
            ex_mem_d.negative   = negative_flag;
            if (!exc) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (halt) begin
                  state_d = ST_HALTED;
               end
            end
         end else begin
            ex_mem_d = '0;
         end
      end
   end

   // Pipeline register, counter and halt state; reset may arrive mid-stall.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ex_mem_q <= ex_mem_reset(RESET_PC);
         state_q  <= ST_RUN;
         cnt_q    <= '0;
      end else begin
         ex_mem_q <= ex_mem_d;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
      end
   end

   // The negative flag is held in the register for later sign-based branches.
   logic unused_mem_negative;
   assign unused_mem_negative = ex_mem_q.negative;

   assign mem_valid      = ex_mem_q.valid;
   assign mem_alu_out    = ex_mem_q.alu_out;
   assign mem_store_data = ex_mem_q.store_data;
   assign mem_pc_plus4   = ex_mem_q.pc_plus4;
   assign mem_rd         = ex_mem_q.rd;
   assign mem_regwen     = ex_mem_q.regwen;
   assign mem_memren     = ex_mem_q.memren;
   assign mem_memwen     = ex_mem_q.memwen;
   assign mem_br_taken   = ex_mem_q.br_taken;
   assign mem_br_target  = ex_mem_q.br_target;
   assign mem_ovf_exc    = ex_mem_q.ovf_exc;
   assign mem_halt       = (state_q == ST_HALTED);
   assign retired_cnt    = cnt_q;

endmodule : ex_mem_latch
